profile_ctrl: RTL and testbench

- Control stage directly upstream of a bank of profiling counters.
- Turns CPU/bus commands and hardware trigger/event signals into the per-channel reset, enable and direction inputs that each counter instance consumes.
- Holds a small per-channel FSM: IDLE / ARMED / RUNNING.

---
 rtl/profile_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_profile_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/profile_ctrl.sv
// ---------------------------------------------------------------------------
// profile_ctrl
//
// Control stage sitting directly in front of a bank of profiling counters.
// It turns CPU/bus commands and a hardware start trigger into the per-channel
// clear, enable and direction inputs that each counter instance consumes.
// Each channel runs a small IDLE / ARMED / RUNNING state machine.
//
// Optional feature (macro PROFILE_CTRL_TIMEOUT_EN):
//   Each channel gets a RUN_WIDTH-bit run-length counter. A channel that has
//   been RUNNING for MAX_RUN cycles drops back to IDLE and raises a sticky
//   timeoutFlag bit. The flag clears on CLEAR / CLEAR_START or on reset.
//   Without the macro there are no run counters and timeoutFlag is 0.
//
// Handshake: cmdValid is a single-cycle strobe that is always accepted; there
// is no ready/backpressure. A command in cycle t is visible from cycle t+1.
//
// Ports:
//   clock            system clock, all state on the rising edge
//   reset            asynchronous active-low reset
//   cmdValid         command strobe
//   cmdAction[2:0]   command code (NOP/START/STOP/CLEAR/ARM/SET_UP/SET_DOWN/
//                    CLEAR_START)
//   cmdMask          channels the command applies to
//   triggerIn        hardware start trigger, rising-edge sensitive
//   eventIn          per-channel qualifying event
//   counterReset     registered one-cycle clear pulse per counter
//   counterEnable    count enable per counter (RUNNING & eventIn)
//   counterDirection 1 = count up, 0 = count down
//   runningMask      channel is RUNNING (FSM state observation)
//   armedMask        channel is ARMED   (FSM state observation)
//   timeoutFlag      sticky run-limit flag (0 unless the option is built in)
// ---------------------------------------------------------------------------
module profile_ctrl #(
  parameter int unsigned          NR_CHANNELS = 4,
  parameter int unsigned          RUN_WIDTH   = 32,
  parameter logic [RUN_WIDTH-1:0] MAX_RUN     = RUN_WIDTH'(32'hFFFF_FFFF)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmdValid,
  input  logic [2:0]             cmdAction,
  input  logic [NR_CHANNELS-1:0] cmdMask,
  input  logic                   triggerIn,
  input  logic [NR_CHANNELS-1:0] eventIn,
  output logic [NR_CHANNELS-1:0] counterReset,
  output logic [NR_CHANNELS-1:0] counterEnable,
  output logic [NR_CHANNELS-1:0] counterDirection,
  output logic [NR_CHANNELS-1:0] runningMask,
  output logic [NR_CHANNELS-1:0] armedMask,
  output logic [NR_CHANNELS-1:0] timeoutFlag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RUNNING = 2'b10
  } ch_state_e;

  localparam logic [2:0] CMD_NOP         = 3'b000;
  localparam logic [2:0] CMD_START       = 3'b001;
  localparam logic [2:0] CMD_STOP        = 3'b010;
  localparam logic [2:0] CMD_CLEAR       = 3'b011;
  localparam logic [2:0] CMD_ARM         = 3'b100;
  localparam logic [2:0] CMD_SET_UP      = 3'b101;
  localparam logic [2:0] CMD_SET_DOWN    = 3'b110;
  localparam logic [2:0] CMD_CLEAR_START = 3'b111;

  ch_state_e              state_q [NR_CHANNELS];
  ch_state_e              state_d [NR_CHANNELS];
  logic [NR_CHANNELS-1:0] dir_q;
  logic [NR_CHANNELS-1:0] dir_d;
  logic [NR_CHANNELS-1:0] clr_q;
  logic [NR_CHANNELS-1:0] clr_d;
  logic                   trig_prev_q;

  logic                   trig_edge;
  logic [NR_CHANNELS-1:0] cmd_hit;
  logic                   is_state_cmd;
  logic                   is_clear_cmd;

  // Rising edge of the trigger against its registered previous value.
  assign trig_edge = triggerIn & ~trig_prev_q;

  assign cmd_hit = cmdValid ? cmdMask : '0;

  // Commands that move the FSM. When one of these hits a channel it takes
  // priority over the trigger and over a run-limit expiry in that cycle.
  assign is_state_cmd = (cmdAction == CMD_START) || (cmdAction == CMD_STOP) ||
                        (cmdAction == CMD_ARM)   || (cmdAction == CMD_CLEAR_START);

  assign is_clear_cmd = (cmdAction == CMD_CLEAR) || (cmdAction == CMD_CLEAR_START);

`ifdef PROFILE_CTRL_TIMEOUT_EN
  localparam logic [RUN_WIDTH-1:0] LAST_RUN = MAX_RUN - 1'b1;

  logic [RUN_WIDTH-1:0]   run_cnt_q [NR_CHANNELS];
  logic [RUN_WIDTH-1:0]   run_cnt_d [NR_CHANNELS];
  logic [NR_CHANNELS-1:0] tmo_q;
  logic [NR_CHANNELS-1:0] tmo_d;
  logic [NR_CHANNELS-1:0] tmo_hit;
`else
  // Run-length parameters only matter when the timeout option is built in.
  logic unused_cfg;
  assign unused_cfg = ^{MAX_RUN, 32'(RUN_WIDTH)};
`endif

  // -------------------------------------------------------------------------
  // Next-state logic per channel
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NR_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      clr_d[i]   = cmd_hit[i] & is_clear_cmd;

      if (cmd_hit[i] && is_state_cmd) begin
        case (cmdAction)
          CMD_STOP: state_d[i] = ST_IDLE;
          CMD_ARM:  state_d[i] = ST_ARMED;
          default:  state_d[i] = ST_RUNNING;  // START, CLEAR_START
        endcase
      end else if (trig_edge && (state_q[i] == ST_ARMED)) begin
        state_d[i] = ST_RUNNING;
      end

      if (cmd_hit[i] && (cmdAction == CMD_SET_UP)) begin
        dir_d[i] = 1'b1;
      end else if (cmd_hit[i] && (cmdAction == CMD_SET_DOWN)) begin
        dir_d[i] = 1'b0;
      end

`ifdef PROFILE_CTRL_TIMEOUT_EN
      // The counter holds the number of RUNNING cycles already completed, so
      // LAST_RUN in the current cycle means this is the MAX_RUN-th one.
      // A state-changing command in the same cycle wins and sets no flag.
      tmo_hit[i] = (state_q[i] == ST_RUNNING) && (run_cnt_q[i] >= LAST_RUN) &&
                   !(cmd_hit[i] && is_state_cmd);
      if (tmo_hit[i]) begin
        state_d[i] = ST_IDLE;
      end

      tmo_d[i] = (tmo_q[i] & ~clr_d[i]) | tmo_hit[i];

      if ((state_d[i] == ST_RUNNING) && (state_q[i] != ST_RUNNING)) begin
        run_cnt_d[i] = '0;
      end else if (state_q[i] == ST_RUNNING) begin
        run_cnt_d[i] = run_cnt_q[i] + 1'b1;
      end else begin
        run_cnt_d[i] = run_cnt_q[i];
      end
`endif
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Reset also cancels any pending counterReset pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
`ifdef PROFILE_CTRL_TIMEOUT_EN
        run_cnt_q[i] <= '0;
`endif
      end
      dir_q       <= '1;
      clr_q       <= '0;
      trig_prev_q <= 1'b0;
`ifdef PROFILE_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
`ifdef PROFILE_CTRL_TIMEOUT_EN
        run_cnt_q[i] <= run_cnt_d[i];
`endif
      end
      dir_q       <= dir_d;
      clr_q       <= clr_d;
      trig_prev_q <= triggerIn;
`ifdef PROFILE_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, except counterEnable which
  // gates the registered RUNNING bit with the live event input.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NR_CHANNELS; i++) begin
      runningMask[i] = (state_q[i] == ST_RUNNING);
      armedMask[i]   = (state_q[i] == ST_ARMED);
    end
  end

  assign counterEnable    = runningMask & eventIn;
  assign counterReset     = clr_q;
  assign counterDirection = dir_q;

`ifdef PROFILE_CTRL_TIMEOUT_EN
  assign timeoutFlag = tmo_q;
`else
  assign timeoutFlag = '0;
`endif

endmodule

// File: tb/tb_profile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_profile_ctrl
//
// Self-checking bench for profile_ctrl. Inputs change on the falling edge;
// outputs are compared on the falling edge against a cycle-level reference
// model of the channel rules. A small up/down counter model driven by the
// DUT outputs stands in for the downstream counter bank.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_profile_ctrl;

  localparam int NR   = 4;
  localparam int MAXR = 8;
  localparam int VW   = 6 * NR;

  localparam logic [2:0] A_NOP         = 3'b000;
  localparam logic [2:0] A_START       = 3'b001;
  localparam logic [2:0] A_STOP        = 3'b010;
  localparam logic [2:0] A_CLEAR       = 3'b011;
  localparam logic [2:0] A_ARM         = 3'b100;
  localparam logic [2:0] A_SET_UP      = 3'b101;
  localparam logic [2:0] A_SET_DOWN    = 3'b110;
  localparam logic [2:0] A_CLEAR_START = 3'b111;

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_RUN   = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          cmd_valid  = 1'b0;
  logic [2:0]    cmd_action = 3'b000;
  logic [NR-1:0] cmd_mask   = '0;
  logic          trigger    = 1'b0;
  logic [NR-1:0] event_in   = '1;

  logic [NR-1:0] counter_reset;
  logic [NR-1:0] counter_enable;
  logic [NR-1:0] counter_direction;
  logic [NR-1:0] running_mask;
  logic [NR-1:0] armed_mask;
  logic [NR-1:0] timeout_flag;

  profile_ctrl #(
    .NR_CHANNELS(NR),
    .RUN_WIDTH  (32),
    .MAX_RUN    (32'(MAXR))
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cmdValid        (cmd_valid),
    .cmdAction       (cmd_action),
    .cmdMask         (cmd_mask),
    .triggerIn       (trigger),
    .eventIn         (event_in),
    .counterReset    (counter_reset),
    .counterEnable   (counter_enable),
    .counterDirection(counter_direction),
    .runningMask     (running_mask),
    .armedMask       (armed_mask),
    .timeoutFlag     (timeout_flag)
  );

  // ---------------- downstream counters ----------------
  int ctr [NR];
  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (counter_reset[i])       ctr[i] <= 0;
      else if (counter_enable[i]) ctr[i] <= counter_direction[i] ? ctr[i] + 1 : ctr[i] - 1;
    end
  end

  // ---------------- reference model ----------------
  int            m_state [NR];
  int            m_run   [NR];
  logic [NR-1:0] m_dir;
  logic [NR-1:0] m_clr;
  logic [NR-1:0] m_tmo;
  logic          m_trig_prev;

  int tests  = 0;
  int failed = 0;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_state[i] = S_IDLE;
      m_run[i]   = 0;
    end
    m_dir       = '1;
    m_clr       = '0;
    m_tmo       = '0;
    m_trig_prev = 1'b0;
  endtask

  // One clock edge worth of channel rules, using the inputs held this cycle.
  task automatic model_advance();
    logic edge_seen;
    edge_seen = trigger && !m_trig_prev;
    for (int i = 0; i < NR; i++) begin
      int nxt;
      bit hit;
      bit moves;
      nxt   = m_state[i];
      hit   = cmd_valid && cmd_mask[i];
      moves = hit && (cmd_action inside {A_START, A_STOP, A_ARM, A_CLEAR_START});
      m_clr[i] = hit && (cmd_action inside {A_CLEAR, A_CLEAR_START});
      if (m_clr[i]) m_tmo[i] = 1'b0;
      if (hit && cmd_action == A_SET_UP)   m_dir[i] = 1'b1;
      if (hit && cmd_action == A_SET_DOWN) m_dir[i] = 1'b0;
      if (moves)
        nxt = (cmd_action == A_STOP) ? S_IDLE : (cmd_action == A_ARM) ? S_ARMED : S_RUN;
      else if (edge_seen && m_state[i] == S_ARMED)
        nxt = S_RUN;
`ifdef PROFILE_CTRL_TIMEOUT_EN
      if (m_state[i] == S_RUN) begin
        m_run[i]++;
        if (!moves && m_run[i] >= MAXR) begin
          nxt      = S_IDLE;
          m_tmo[i] = 1'b1;
        end
      end
      if (nxt == S_RUN && m_state[i] != S_RUN) m_run[i] = 0;
`endif
      m_state[i] = nxt;
    end
    m_trig_prev = trigger;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NR-1:0] run;
    logic [NR-1:0] arm;
    for (int i = 0; i < NR; i++) begin
      run[i] = (m_state[i] == S_RUN);
      arm[i] = (m_state[i] == S_ARMED);
    end
`ifdef PROFILE_CTRL_TIMEOUT_EN
    return {m_clr, run & event_in, m_dir, run, arm, m_tmo};
`else
    return {m_clr, run & event_in, m_dir, run, arm, {NR{1'b0}}};
`endif
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {counter_reset, counter_enable, counter_direction, running_mask, armed_mask, timeout_flag};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] a, input logic [NR-1:0] m);
    cmd_valid  = v;
    cmd_action = a;
    cmd_mask   = m;
  endtask

  task automatic step();
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    drive(1'b0, A_NOP, '0);
    event_in = '1;
    @(negedge clock);
    @(negedge clock);
    tests++; if (dut_vec() !== {{NR{1'b0}}, {NR{1'b0}}, {NR{1'b1}}, {3*NR{1'b0}}}) begin
      failed++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), {{NR{1'b0}}, {NR{1'b0}}, {NR{1'b1}}, {3*NR{1'b0}}});
    end
    reset = 1'b1;
    step();
    tests++; if (dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start_stop();
    event_in = 4'b1111;
    drive(1'b1, A_START, 4'b0001);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (running_mask !== 4'b0001 || counter_enable !== 4'b0001) begin
      failed++; $display("FAIL start_running got run=%b en=%b exp run=0001 en=0001", running_mask, counter_enable);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      tests++; if (dut_vec() !== exp_vec()) begin
        failed++; $display("FAIL start_hold cyc=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    drive(1'b1, A_STOP, 4'b0001);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (counter_enable !== 4'b0000 || running_mask !== 4'b0000) begin
      failed++; $display("FAIL stop_enable got en=%b run=%b exp 0000", counter_enable, running_mask);
    end
  endtask

  task automatic test_clear_start();
    event_in = 4'b1111;
    drive(1'b1, A_CLEAR_START, 4'b0011);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (counter_reset !== 4'b0011 || running_mask !== 4'b0011 || counter_enable !== 4'b0011) begin
      failed++; $display("FAIL clear_start_t1 got rst=%b run=%b en=%b exp 0011", counter_reset, running_mask, counter_enable);
    end
    step();
    tests++; if (counter_reset !== 4'b0000 || ctr[0] != 0 || ctr[1] != 0) begin
      failed++; $display("FAIL clear_start_t2 got rst=%b c0=%0d c1=%0d exp rst=0000 c=0", counter_reset, ctr[0], ctr[1]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests++; if (dut_vec() !== exp_vec()) begin
        failed++; $display("FAIL clear_start_run cyc=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    tests++; if (ctr[0] != 5 || ctr[1] != 5) begin
      failed++; $display("FAIL clear_start_count got c0=%0d c1=%0d exp 5", ctr[0], ctr[1]);
    end
    drive(1'b1, A_STOP, 4'b1111);
    step();
    drive(1'b0, A_NOP, '0);
  endtask

  task automatic test_event_dir();
    logic [3:0] pat;
    pat = 4'b0101;
    drive(1'b1, A_START, 4'b0010);
    step();
    drive(1'b0, A_NOP, '0);
    for (int k = 0; k < 4; k++) begin
      event_in = {2'b11, ~pat[k], 1'b1};
      #1;
      tests++; if (counter_enable[1] !== ~pat[k] || dut_vec() !== exp_vec()) begin
        failed++; $display("FAIL event_follow k=%0d got en1=%b exp=%b vec=%h/%h", k, counter_enable[1], ~pat[k], dut_vec(), exp_vec());
      end
      step();
    end
    event_in = 4'b1111;
    drive(1'b1, A_SET_DOWN, 4'b0010);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (counter_direction !== 4'b1101 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL set_down got dir=%b exp=1101", counter_direction);
    end
    drive(1'b1, A_STOP, 4'b1111);
    step();
    drive(1'b0, A_NOP, '0);
  endtask

  task automatic test_trigger();
    trigger = 1'b0;
    drive(1'b1, A_ARM, 4'b0100);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (armed_mask !== 4'b0100 || running_mask !== 4'b0000) begin
      failed++; $display("FAIL arm got arm=%b run=%b exp arm=0100 run=0000", armed_mask, running_mask);
    end
    trigger = 1'b1;
    step();
    tests++; if (running_mask !== 4'b0100 || armed_mask !== 4'b0000) begin
      failed++; $display("FAIL trig_edge_start got run=%b arm=%b exp run=0100", running_mask, armed_mask);
    end
    drive(1'b1, A_ARM, 4'b0100);
    step();
    drive(1'b0, A_NOP, '0);
    step();
    tests++; if (armed_mask !== 4'b0100 || running_mask !== 4'b0000) begin
      failed++; $display("FAIL trig_level_ignored got arm=%b run=%b exp arm=0100", armed_mask, running_mask);
    end
    trigger = 1'b0;
    step();
    tests++; if (armed_mask !== 4'b0100 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL trig_low_armed got arm=%b exp=0100", armed_mask);
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    tests++; if (running_mask !== 4'b0100 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL trig_second_edge got run=%b exp=0100", running_mask);
    end
    drive(1'b1, A_STOP, 4'b1111);
    step();
    drive(1'b0, A_NOP, '0);
  endtask

  task automatic test_cmd_trigger_collision();
    trigger = 1'b0;
    drive(1'b1, A_ARM, 4'b1001);
    step();
    drive(1'b1, A_STOP, 4'b1000);
    trigger = 1'b1;
    step();
    drive(1'b0, A_NOP, '0);
    trigger = 1'b0;
    tests++; if (running_mask !== 4'b0001 || armed_mask !== 4'b0000 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL collision got run=%b arm=%b exp run=0001 arm=0000", running_mask, armed_mask);
    end
    drive(1'b1, A_STOP, 4'b1111);
    step();
    drive(1'b0, A_NOP, '0);
  endtask

  task automatic test_reset_mid_run();
    event_in = 4'b1111;
    drive(1'b1, A_START, 4'b0101);
    step();
    drive(1'b0, A_NOP, '0);
    step();
    drive(1'b1, A_CLEAR, 4'b0101);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (counter_reset !== 4'b0101 || running_mask !== 4'b0101 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL pre_reset got rst=%b run=%b exp 0101", counter_reset, running_mask);
    end
    #2 reset = 1'b0;
    #1;
    tests++; if (running_mask !== 4'b0000 || counter_enable !== 4'b0000 || counter_reset !== 4'b0000 || counter_direction !== 4'b1111) begin
      failed++; $display("FAIL async_reset got run=%b en=%b rst=%b dir=%b", running_mask, counter_enable, counter_reset, counter_direction);
    end
    #1 reset = 1'b1;
    model_reset();
    step();
    tests++; if (dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL after_reset got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

`ifdef PROFILE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    event_in = 4'b1111;
    drive(1'b1, A_START, 4'b0001);
    step();
    drive(1'b0, A_NOP, '0);
    for (int k = 0; k < MAXR - 1; k++) step();
    tests++; if (running_mask[0] !== 1'b1 || timeout_flag[0] !== 1'b0) begin
      failed++; $display("FAIL timeout_early got run=%b tmo=%b", running_mask, timeout_flag);
    end
    step();
    tests++; if (running_mask[0] !== 1'b0 || timeout_flag !== 4'b0001 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL timeout_hit got run=%b tmo=%b exp run0=0 tmo=0001", running_mask, timeout_flag);
    end
    step();
    tests++; if (timeout_flag !== 4'b0001) begin
      failed++; $display("FAIL timeout_sticky got tmo=%b exp=0001", timeout_flag);
    end
    drive(1'b1, A_CLEAR, 4'b0001);
    step();
    drive(1'b0, A_NOP, '0);
    tests++; if (timeout_flag !== 4'b0000 || dut_vec() !== exp_vec()) begin
      failed++; $display("FAIL timeout_clear got tmo=%b exp=0000", timeout_flag);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b1, 3'($urandom_range(0, 7)), NR'($urandom_range(0, 15)));
      else                           drive(1'b0, A_NOP, '0);
      if ($urandom_range(0, 3) == 0) trigger = ~trigger;
      event_in = NR'($urandom_range(0, 15));
      step();
      tests++; if (dut_vec() !== exp_vec()) begin
        failed++; $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    drive(1'b0, A_NOP, '0);
    trigger = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_start_stop();
    test_clear_start();
    test_event_dir();
    test_trigger();
    test_cmd_trigger_collision();
    test_reset_mid_run();
`ifdef PROFILE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule
